// File: rtl/fir_hls_mac_pipe.sv
// Pipelined signed multiply-accumulate unit for the FIR datapath.
// Samples are captured in an input register, multiplied, carried through
// NUM_STAGE product registers and then summed into a saturating accumulator
// that emits one result per first..last tap burst.
module fir_hls_mac_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 8,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 28
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  first,
  input  logic                  last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  sat
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LAST = NUM_STAGE - 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Input register stage
  logic                         in_v_q;
  logic                         in_f_q;
  logic                         in_l_q;
  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH:0]   b_q;

  // Product pipeline
  logic                         v_pipe [NUM_STAGE];
  logic                         f_pipe [NUM_STAGE];
  logic                         l_pipe [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0]  p_pipe [NUM_STAGE];

  // Accumulate stage
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         sat_acc;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic                         sat_base;
  logic signed [ACC_WIDTH:0]    sum_g;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic                         sat_next;

  // The coefficient always gets one extra MSB so a single signed multiply
  // covers both modes: a copy of its sign bit when signed, 0 when unsigned.
  logic din1_msb;
  assign din1_msb = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;

  // Full-precision product; the true value always fits PW bits, so the
  // extra bit of prod_full is just a sign copy and the resize is exact.
  logic signed [PW:0]           prod_full;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  assign prod_full = (PW+1)'(a_q) * (PW+1)'(b_q);
  assign prod_ext  = ACC_WIDTH'(prod_full);

  // Valid bits of the input register and product stages; reset flushes bursts in flight.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all registers
  // sample their inputs from before the edge, regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      in_v_q <= 1'b0;
      for (int i = 0; i < NUM_STAGE; i++) v_pipe[i] <= 1'b0;
    end else if (ce) begin
      in_v_q    <= in_valid;
      v_pipe[0] <= in_v_q;
      for (int i = 1; i < NUM_STAGE; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  // Payload of the input register and product stages, advanced on every enabled cycle.
  // NOTE: payload registers are deliberately left out of reset; they are only
  // ever consumed under their valid bit, which is reset.
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      in_f_q    <= first;
      in_l_q    <= last;
      a_q       <= din0;
      b_q       <= {din1_msb, din1};
      f_pipe[0] <= in_f_q;
      l_pipe[0] <= in_l_q;
      p_pipe[0] <= prod_ext;
      for (int i = 1; i < NUM_STAGE; i++) begin
        f_pipe[i] <= f_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
        p_pipe[i] <= p_pipe[i-1];
      end
    end
  end

  // Next accumulator value: restart on first, add with one guard bit, clamp on overflow.
  // NOTE: every output of this block is assigned a default up front so no
  // path through it leaves a value unassigned, which would infer a latch.
  always_comb begin
    acc_base = f_pipe[LAST] ? '0 : acc;
    sat_base = f_pipe[LAST] ? 1'b0 : sat_acc;
    sum_g    = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(p_pipe[LAST]);
    acc_next = sum_g[ACC_WIDTH-1:0];
    sat_next = sat_base;
    if (sum_g[ACC_WIDTH] != sum_g[ACC_WIDTH-1]) begin
      acc_next = sum_g[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      sat_next = 1'b1;
    end
  end

  // Accumulator and result registers; dout/sat hold between results, out_valid pulses.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc       <= '0;
      sat_acc   <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= v_pipe[LAST] & l_pipe[LAST];
      if (v_pipe[LAST]) begin
        acc     <= acc_next;
        sat_acc <= sat_next;
        if (l_pipe[LAST]) begin
          dout <= acc_next;
          sat  <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_hls_mac_pipe.sv
// Scoreboard bench for fir_hls_mac_pipe. Six instances with different
// signedness, accumulator width and pipeline depth share one stimulus stream;
// each has its own arithmetic reference model, expected-result queue and monitor.
module tb_fir_hls_mac_pipe;

  typedef struct packed {
    longint v;
    logic   s;
    int     cyc;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        in_valid;
  logic        first;
  logic        last;
  logic [15:0] din0;
  logic [7:0]  din1;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 ap_clk = ~ap_clk;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Instance configurations: pipeline depth, coefficient signedness, accumulator width
  function automatic int ns_of(int i);
    case (i)
      3: return 1;
      4: return 3;
      5: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int sg_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int aw_of(int i);
    return (i == 2) ? 24 : 28;
  endfunction

  for (genvar g = 0; g < 6; g++) begin : cfg
    localparam int NS = ns_of(g);
    localparam int SG = sg_of(g);
    localparam int AW = aw_of(g);
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic          ov;
    logic          st;
    logic [AW-1:0] dq;

    fir_hls_mac_pipe #(
      .DIN0_WIDTH (16),
      .DIN1_WIDTH (8),
      .DIN1_SIGNED(SG),
      .NUM_STAGE  (NS),
      .ACC_WIDTH  (AW)
    ) u_dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ce       (ce),
      .in_valid (in_valid),
      .first    (first),
      .last     (last),
      .din0     (din0),
      .din1     (din1),
      .out_valid(ov),
      .dout     (dq),
      .sat      (st)
    );

    exp_t   q[$];
    longint m_acc   = 0;
    bit     m_sat   = 1'b0;
    int     ecnt    = 0;
    int     rst_cnt = 0;

    // Reference model: burst arithmetic on plain integers, enabled-edge timestamps
    always @(posedge ap_clk) begin
      longint p;
      longint s;
      if (ap_rst) begin
        q.delete();
        m_acc = 0;
        m_sat = 1'b0;
        rst_cnt++;
      end else if (ce) begin
        ecnt++;
        if (in_valid) begin
          p = longint'($signed(din0)) *
              ((SG != 0) ? longint'($signed(din1)) : longint'(din1));
          if (first) begin
            m_acc = p;
            m_sat = 1'b0;
          end else begin
            s = m_acc + p;
            if (s > MAXV) begin
              s = MAXV;
              m_sat = 1'b1;
            end else if (s < MINV) begin
              s = MINV;
              m_sat = 1'b1;
            end
            m_acc = s;
          end
          if (last) q.push_back('{v: m_acc, s: m_sat, cyc: ecnt + NS + 1});
        end
      end
    end

    longint held_v   = 0;
    bit     held_s   = 1'b0;
    int     rst_seen = 0;
    bit     drained  = 1'b0;

    // Monitor: consumes results on ce-qualified cycles and checks held outputs
    always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst && ce) begin
        if (rst_seen != rst_cnt) begin
          rst_seen = rst_cnt;
          held_v   = 0;
          held_s   = 1'b0;
        end
        if (ov) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_spurious_out_valid", g), longint'(ov), 0);
          end else begin
            e = q.pop_front();
            check($sformatf("cfg%0d_dout", g), longint'($signed(dq)), e.v);
            check($sformatf("cfg%0d_sat", g), longint'(st), longint'(e.s));
            check($sformatf("cfg%0d_latency_cycle", g), longint'(ecnt), longint'(e.cyc));
            held_v = e.v;
            held_s = e.s;
          end
        end else begin
          if (q.size() > 0 && q[0].cyc <= ecnt) begin
            check($sformatf("cfg%0d_missing_out_valid", g), longint'(ov), 1);
            e = q.pop_front();
            held_v = e.v;
            held_s = e.s;
          end
          check($sformatf("cfg%0d_dout_hold", g), longint'($signed(dq)), held_v);
          check($sformatf("cfg%0d_sat_hold", g), longint'(st), longint'(held_s));
        end
      end
      if (done && !drained) begin
        drained = 1'b1;
        check($sformatf("cfg%0d_results_outstanding", g), longint'(q.size()), 0);
      end
    end
  end

  task automatic drive(bit c, bit v, bit f, bit l, int a, int b);
    ce       = c;
    in_valid = v;
    first    = f;
    last     = l;
    din0     = 16'(a);
    din1     = 8'(b);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    ap_rst   = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    first    = 1'b0;
    last     = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("reset_out_valid", longint'(cfg[0].ov), 0);
    check("reset_dout", longint'(cfg[0].dq), 0);
    check("reset_sat", longint'(cfg[0].st), 0);
    @(posedge ap_clk);
    #1;

    // Single product: -3 * 200
    drive(1, 1, 1, 1, -3, 200);
    idle(8);

    // Signedness corner cases
    drive(1, 1, 1, 1, 1, 255);
    idle(6);
    drive(1, 1, 1, 1, -32768, 255);
    idle(6);

    // Four-sample burst, back to back
    drive(1, 1, 1, 0, 1000, 10);
    drive(1, 1, 0, 0, -2000, 10);
    drive(1, 1, 0, 0, 3000, 10);
    drive(1, 1, 0, 1, -4000, 10);
    idle(6);

    // Same burst with bubbles between samples
    drive(1, 1, 1, 0, 1000, 10);   idle(2);
    drive(1, 1, 0, 0, -2000, 10);  idle(2);
    drive(1, 1, 0, 0, 3000, 10);   idle(2);
    drive(1, 1, 0, 1, -4000, 10);
    idle(6);

    // Same burst with ce low for 5 cycles mid-burst (inputs garbage meanwhile)
    drive(1, 1, 1, 0, 1000, 10);
    drive(1, 1, 0, 0, -2000, 10);
    repeat (5) drive(0, 1, 1, 1, 12345, 77);
    drive(1, 1, 0, 0, 3000, 10);
    drive(1, 1, 0, 1, -4000, 10);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    idle(6);

    // Saturation on the narrow accumulator, then a clean burst
    drive(1, 1, 1, 0, -32768, 255);
    drive(1, 1, 0, 1, -32768, 255);
    drive(1, 1, 1, 1, 2, 3);
    idle(6);

    // Positive saturation on all widths, then recovery from the clamped value
    for (int i = 0; i < 40; i++) drive(1, 1, i == 0, 0, 32767, 255);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, i == 2, -32768, 255);
    // Negative saturation on all widths
    for (int i = 0; i < 30; i++) drive(1, 1, i == 0, i == 29, -32768, 255);
    idle(6);

    // Restart: first while a burst is open discards the partial sum
    drive(1, 1, 1, 0, 5, 7);
    drive(1, 1, 0, 0, 6, 7);
    drive(1, 1, 1, 0, 1, 2);
    drive(1, 1, 0, 1, 3, 2);
    idle(6);

    // Reset in the middle of a burst: nothing from it may appear
    drive(1, 1, 1, 0, 9, 9);
    drive(1, 1, 0, 0, 9, 9);
    ap_rst = 1'b1;
    drive(1, 1, 0, 1, 9, 9);
    ap_rst = 1'b0;
    check("abort_reset_out_valid", longint'(cfg[0].ov), 0);
    check("abort_reset_dout", longint'(cfg[0].dq), 0);
    for (int i = 0; i < 5; i++) drive(1, 1, i == 0, i == 4, 1, 1);
    idle(8);

    // One result per cycle
    for (int i = 0; i < 20; i++)
      drive(1, 1, 1, 1, int'($urandom_range(65535)), int'($urandom_range(255)));
    idle(6);

    // Randomised traffic with ce gaps, bubbles, restarts and open bursts
    for (int i = 0; i < 600; i++)
      drive($urandom_range(9) != 0, $urandom_range(3) != 0,
            $urandom_range(4) == 0, $urandom_range(4) == 0,
            int'($urandom_range(65535)), int'($urandom_range(255)));
    idle(12);

    done = 1'b1;
    repeat (3) @(negedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
